// File: rtl/bfsk_pkg.sv
// Shared sample/product types and constants for the BFSK delay-and-multiply discriminator.
package bfsk_pkg;

  localparam int SAMPLE_W = 8;
  localparam int PROD_W   = 16;
  localparam logic [SAMPLE_W-1:0] ZERO_LEVEL = 8'h80;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [PROD_W-1:0]   prod_t;

  // Offset-binary to two's complement: flipping the MSB recentres 0x80 onto zero.
  function automatic sample_t to_signed(input logic [SAMPLE_W-1:0] din);
    return sample_t'(din ^ ZERO_LEVEL);
  endfunction

endpackage

// File: rtl/bfsk_mavg.sv
// Running-sum moving average over the last 2^DEPTH_S products; avg is the combinational
// next value so the caller can register it together with decisions derived from it.
module bfsk_mavg
  import bfsk_pkg::*;
#(
  parameter int DEPTH_S = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  prod_t prod_r,
  output prod_t avg
);

  localparam int NTAP  = 1 << DEPTH_S;
  localparam int SUM_W = PROD_W + DEPTH_S;

  prod_t                   pdly [NTAP];
  logic signed [SUM_W-1:0] sum_r;
  logic signed [SUM_W-1:0] sum_next;
  logic signed [SUM_W-1:0] new_ext;
  logic signed [SUM_W-1:0] old_ext;

  // The sum is wide enough for NTAP full-scale products, so no saturation is needed.
  always_comb begin
    new_ext  = SUM_W'(prod_r);
    old_ext  = SUM_W'(pdly[NTAP-1]);
    sum_next = sum_r + new_ext - old_ext;
    avg      = prod_t'(sum_next >>> DEPTH_S);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r <= '0;
      for (int i = 0; i < NTAP; i++) pdly[i] <= '0;
    end else begin
      sum_r   <= sum_next;
      pdly[0] <= prod_r;
      for (int i = 1; i < NTAP; i++) pdly[i] <= pdly[i-1];
    end
  end

endmodule

// File: rtl/bfsk_discr.sv
// Delay-and-multiply BFSK discriminator: x[n]*x[n-DEPTH_D], smoothed, with hard decision,
// valid flag and transition strobe. One sample consumed per clk edge.
module bfsk_discr
  import bfsk_pkg::*;
#(
  parameter int DEPTH_D = 20,
  parameter int DEPTH_S = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SAMPLE_W-1:0]      din,
  output logic signed [PROD_W-1:0] dout,
  output logic                     det,
  output logic                     en,
  output logic                     sync
);

  localparam int FILL  = DEPTH_D + (1 << DEPTH_S) + 2;
  localparam int CNT_W = $clog2(FILL + 1);

  sample_t          x_r;
  sample_t          dly [DEPTH_D];
  prod_t            prod_r;
  prod_t            avg;
  logic [CNT_W-1:0] cnt;
  logic             en_next;
  logic             det_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_r <= '0;
      for (int i = 0; i < DEPTH_D; i++) dly[i] <= '0;
    end else begin
      x_r    <= to_signed(din);
      dly[0] <= x_r;
      for (int i = 1; i < DEPTH_D; i++) dly[i] <= dly[i-1];
    end
  end

  // Full-precision 8x8 signed product; -128*-128 = 16384 still fits in 16 bits.
  always_ff @(posedge clk) begin
    if (rst) prod_r <= '0;
    else     prod_r <= prod_t'(x_r) * prod_t'(dly[DEPTH_D-1]);
  end

  bfsk_mavg #(.DEPTH_S(DEPTH_S)) u_mavg (
    .clk    (clk),
    .rst    (rst),
    .prod_r (prod_r),
    .avg    (avg)
  );

  // Decision uses the incoming en so det rises together with en and the strobe,
  // gated by the already-registered en, stays quiet on that first valid cycle.
  always_comb begin
    en_next  = en | (cnt == CNT_W'(FILL - 1));
    det_next = en_next & ~avg[PROD_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      en   <= 1'b0;
      dout <= '0;
      det  <= 1'b0;
      sync <= 1'b0;
    end else begin
      if (cnt != CNT_W'(FILL)) cnt <= cnt + CNT_W'(1);
      en   <= en_next;
      dout <= avg;
      det  <= det_next;
      sync <= en & (det_next ^ det);
    end
  end

endmodule

// File: tb/tb_bfsk_discr.sv
// Directed bench for bfsk_discr: default instance plus two DEPTH_D=1 instances for averaging corners.
`timescale 1ns/1ps
module tb_bfsk_discr;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;

  logic signed [15:0] dout, s0_dout, s1_dout;
  logic det, en, sync;
  logic s0_det, s0_en, s0_sync;
  logic s1_det, s1_en, s1_sync;

  int checks = 0;
  int errors = 0;
  int sync_pulses = 0;

  typedef struct {
    logic [7:0] din;
    int         s0_dout;
    logic       s0_det;
    logic       s0_sync;
    int         s1_dout;
    logic       s1_det;
  } vec_t;

  vec_t vecs [10];

  bfsk_discr dut (
    .clk (clk), .rst (rst), .din (din),
    .dout (dout), .det (det), .en (en), .sync (sync)
  );

  bfsk_discr #(.DEPTH_D(1), .DEPTH_S(0)) dut_s0 (
    .clk (clk), .rst (rst), .din (din),
    .dout (s0_dout), .det (s0_det), .en (s0_en), .sync (s0_sync)
  );

  bfsk_discr #(.DEPTH_D(1), .DEPTH_S(1)) dut_s1 (
    .clk (clk), .rst (rst), .din (din),
    .dout (s1_dout), .det (s1_det), .en (s1_en), .sync (s1_sync)
  );

  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one sample through one rising edge, then sample outputs on the falling edge.
  task automatic applyStimulus(input logic [7:0] d, input logic r);
    din = d;
    rst = r;
    @(posedge clk);
    @(negedge clk);
    if (sync) sync_pulses++;
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input int e_dout, input int e_det,
                             input int e_en, input int e_sync);
    checkValue({name, ".dout"}, dout, e_dout);
    checkValue({name, ".det"},  det,  e_det);
    checkValue({name, ".en"},   en,   e_en);
    checkValue({name, ".sync"}, sync, e_sync);
  endtask

  function automatic logic [7:0] square(input int k);
    return ((k / 20) % 2 == 0) ? 8'hFF : 8'h01;
  endfunction

  initial begin
    vecs[0] = '{8'hFF,      0, 1'b1, 1'b0,    0, 1'b1};
    vecs[1] = '{8'hFF,      0, 1'b1, 1'b0,    0, 1'b1};
    vecs[2] = '{8'h01,      0, 1'b1, 1'b0,    0, 1'b1};
    vecs[3] = '{8'h01,  16129, 1'b1, 1'b0, 8064, 1'b1};
    vecs[4] = '{8'hFF, -16129, 1'b0, 1'b1,    0, 1'b1};
    vecs[5] = '{8'hFF,  16129, 1'b1, 1'b1,    0, 1'b1};
    vecs[6] = '{8'h01, -16129, 1'b0, 1'b1,    0, 1'b1};
    vecs[7] = '{8'h01,  16129, 1'b1, 1'b1,    0, 1'b1};
    vecs[8] = '{8'hFF, -16129, 1'b0, 1'b1,    0, 1'b1};
    vecs[9] = '{8'hFF,  16129, 1'b1, 1'b1,    0, 1'b1};

    din = 8'hFF;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'hFF, 1'b1);
      checkOutput("reset", 0, 0, 0, 0);
    end
    checkValue("reset.s0_dout", s0_dout, 0);

    // Fill from reset with constant 0xFF: en rises exactly at sample 24.
    applyStimulus(8'hFF, 1'b0);
    checkOutput("release1", 0, 0, 0, 0);
    for (int n = 2; n <= 22; n++) applyStimulus(8'hFF, 1'b0);
    checkOutput("fill22", 0, 0, 0, 0);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("fill23", 8064, 0, 0, 0);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("en_rise24", 16129, 1, 1, 0);
    for (int n = 25; n <= 100; n++) applyStimulus(8'hFF, 1'b0);
    checkOutput("steady_ff", 16129, 1, 1, 0);
    checkValue("no_sync_ff", sync_pulses, 0);

    // Square wave of period 40 samples: product turns negative for good at sample 122.
    sync_pulses = 0;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(square(k), 1'b0);
      if (k == 22) checkOutput("sq123", 0, 1, 1, 0);
      if (k == 23) checkOutput("sq124", -16129, 0, 1, 1);
      if (k == 24) checkOutput("sq125", -16129, 0, 1, 0);
    end
    checkOutput("sq_settled", -16129, 0, 1, 0);
    checkValue("sq_sync_count", sync_pulses, 1);

    for (int n = 0; n < 30; n++) applyStimulus(8'h00, 1'b0);
    checkOutput("const_00", 16384, 1, 1, 0);

    for (int n = 0; n < 30; n++) applyStimulus(8'h80, 1'b0);
    checkOutput("const_80", 0, 1, 1, 0);
    checkValue("const_80.s1_dout", s1_dout, 0);

    // Pattern FF,FF,01,01 gives alternating +/-16129 products on the DEPTH_D=1 instances.
    for (int j = 0; j < 10; j++) begin
      applyStimulus(vecs[j].din, 1'b0);
      checkValue($sformatf("alt%0d.s0_dout", j), s0_dout, vecs[j].s0_dout);
      checkValue($sformatf("alt%0d.s0_det", j),  s0_det,  vecs[j].s0_det);
      checkValue($sformatf("alt%0d.s0_sync", j), s0_sync, vecs[j].s0_sync);
      checkValue($sformatf("alt%0d.s1_dout", j), s1_dout, vecs[j].s1_dout);
      checkValue($sformatf("alt%0d.s1_det", j),  s1_det,  vecs[j].s1_det);
      checkValue($sformatf("alt%0d.s1_sync", j), s1_sync, 0);
    end
    checkValue("alt.s0_en", s0_en, 1);
    checkValue("alt.s1_en", s1_en, 1);

    // Reset in the middle of a steady stream restarts the fill count.
    for (int n = 0; n < 50; n++) applyStimulus(8'hFF, 1'b0);
    checkOutput("pre_mid_reset", 16129, 1, 1, 0);
    applyStimulus(8'hFF, 1'b1);
    checkOutput("mid_reset", 0, 0, 0, 0);
    checkValue("mid_reset.s1_dout", s1_dout, 0);
    for (int n = 1; n <= 22; n++) applyStimulus(8'hFF, 1'b0);
    checkOutput("refill22", 0, 0, 0, 0);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("refill23", 8064, 0, 0, 0);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("refill24", 16129, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
